useq_sequencer: RTL

- Microprogram sequencer with a writable control store, a call/return stack, two condition flags and a start/done handshake.
- Drives the 7-bit datapath control bus, one microword per clock.
- A host loads microcode while the sequencer is idle, pulses start, and waits for done.
- Replaces a fixed-ROM controller so datapath sequences can be changed without RTL edits.

---
 rtl/useq_pkg.sv | 22 ++
 rtl/useq_stack.sv | 63 ++++++
 rtl/useq_sequencer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/useq_pkg.sv
// Shared opcodes, FSM state encoding and word-width helper for the microprogram sequencer.
package useq_pkg;

  localparam logic [2:0] OP_CONT = 3'b000;
  localparam logic [2:0] OP_JZ   = 3'b001;
  localparam logic [2:0] OP_JMP  = 3'b010;
  localparam logic [2:0] OP_JNZ  = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b110;
  localparam logic [2:0] OP_JC   = 3'b111;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  function automatic int unsigned word_width(input int unsigned aw, input int unsigned cw);
    return 3 + aw + cw;
  endfunction

endpackage

// File: rtl/useq_stack.sv
// Call/return LIFO. With Overwrite set, a push while full replaces the top entry and a pop
// while empty leaves the pointer at zero; top_o reads zero when empty.
module useq_stack #(
  parameter int unsigned W         = 4,
  parameter int unsigned Depth     = 4,
  parameter bit          Overwrite = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] top_o
);

  localparam int unsigned SpW  = $clog2(Depth + 1);
  localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [SpW-1:0]  sp_q, sp_d;
  logic [W-1:0]    mem_q [Depth];
  logic [IdxW-1:0] top_idx, wr_idx;
  logic            wr_en;

  assign full_o  = (sp_q == SpW'(Depth));
  assign empty_o = (sp_q == '0);
  assign top_idx = IdxW'(sp_q - SpW'(1));
  assign top_o   = empty_o ? '0 : mem_q[top_idx];

  always_comb begin
    sp_d   = sp_q;
    wr_en  = 1'b0;
    wr_idx = IdxW'(sp_q);
    if (push_i) begin
      if (!full_o) begin
        wr_en = 1'b1;
        sp_d  = sp_q + SpW'(1);
      end else if (Overwrite) begin
        wr_en  = 1'b1;
        wr_idx = top_idx;
      end
    end else if (pop_i && !empty_o) begin
      sp_d = sp_q - SpW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Entry storage is deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_idx] <= data_i;
    end
  end

endmodule

// File: rtl/useq_sequencer.sv
// Microprogram sequencer with writable control store and call stack.
// Define USEQ_STACK_CHECK_EN to trap stack overflow/underflow onto the sticky err output.
module useq_sequencer
  import useq_pkg::*;
#(
  parameter int unsigned AW = 4,
  parameter int unsigned CW = 7,
  parameter int unsigned SD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_en,
  input  logic [AW-1:0]     ld_addr,
  input  logic [3+AW+CW-1:0] ld_data,
  input  logic              start,
  input  logic [AW-1:0]     start_addr,
  input  logic              z,
  input  logic              c,
  output logic [CW-1:0]     ctrl_bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [AW-1:0]     upc
);

  localparam int unsigned WW = word_width(AW, CW);

`ifdef USEQ_STACK_CHECK_EN
  localparam bit StackOverwrite = 1'b0;
`else
  localparam bit StackOverwrite = 1'b1;
`endif

  logic [WW-1:0] store_q [2**AW];

  state_e        state_q, state_d;
  logic [AW-1:0] upc_q, upc_d;
  logic [CW-1:0] ctrl_q, ctrl_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [WW-1:0] word;
  logic [2:0]    op;
  logic [AW-1:0] br;
  logic [AW-1:0] upc_inc;
  logic          stk_push, stk_pop, stk_full, stk_empty;
  logic [AW-1:0] stk_top;

  always_ff @(posedge clk) begin
    if (ld_en && (state_q == StIdle)) begin
      store_q[ld_addr] <= ld_data;
    end
  end

  assign word    = store_q[upc_q];
  assign op      = word[WW-1 -: 3];
  assign br      = word[CW +: AW];
  assign upc_inc = upc_q + AW'(1);

  useq_stack #(
    .W        (AW),
    .Depth    (SD),
    .Overwrite(StackOverwrite)
  ) u_stack (
    .clk_i  (clk),
    .rst_i  (reset),
    .push_i (stk_push),
    .pop_i  (stk_pop),
    .data_i (upc_inc),
    .full_o (stk_full),
    .empty_o(stk_empty),
    .top_o  (stk_top)
  );

`ifdef USEQ_STACK_CHECK_EN
  logic err_q, err_d;
  logic fault;
  assign err = err_q;
`else
  logic unused_stk_flags;
  assign unused_stk_flags = ^{stk_full, stk_empty};
  assign err = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    upc_d    = upc_q;
    ctrl_d   = ctrl_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
`ifdef USEQ_STACK_CHECK_EN
    err_d    = err_q;
    fault    = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        ctrl_d = '0;
        busy_d = 1'b0;
        if (start) begin
          state_d = StRun;
          upc_d   = start_addr;
          busy_d  = 1'b1;
`ifdef USEQ_STACK_CHECK_EN
          err_d   = 1'b0;
`endif
        end
      end
      StRun: begin
        ctrl_d = word[CW-1:0];
        unique case (op)
          OP_CONT: upc_d = upc_inc;
          OP_JZ:   upc_d = z ? br : upc_inc;
          OP_JMP:  upc_d = br;
          OP_JNZ:  upc_d = z ? upc_inc : br;
          OP_CALL: begin
`ifdef USEQ_STACK_CHECK_EN
            fault = stk_full;
`endif
            stk_push = 1'b1;
            upc_d    = br;
          end
          OP_RET: begin
`ifdef USEQ_STACK_CHECK_EN
            fault = stk_empty;
`endif
            stk_pop = 1'b1;
            upc_d   = stk_top;
          end
          OP_HALT: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
          end
          OP_JC:   upc_d = c ? br : upc_inc;
          default: upc_d = upc_inc;
        endcase
`ifdef USEQ_STACK_CHECK_EN
        // A trapped stack op aborts to idle and leaves the stack untouched.
        if (fault) begin
          stk_push = 1'b0;
          stk_pop  = 1'b0;
          upc_d    = upc_q;
          ctrl_d   = '0;
          busy_d   = 1'b0;
          state_d  = StIdle;
          err_d    = 1'b1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      upc_q   <= '0;
      ctrl_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      ctrl_q  <= ctrl_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef USEQ_STACK_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`endif

  assign ctrl_bus = ctrl_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign upc      = upc_q;

endmodule
